vcd_trig_gen: RTL and testbench
===============================

# vcd_trig_gen

Synchronous VCD dump-window trigger generator. It snoops register writes to the SoC scratch register reserved for dump control and turns software start/stop requests into a clean, level-type `trig_o` window. Minimum-high and minimum-low times are guaranteed, and each window gets an ID and a cycle count. It sits directly upstream of the testbench VCD dump FSM, which consumes `trig_o` as its triggered-mode input.

## Interface
- `AddrWidth`, default 32: width of the snooped write address.
- `DataWidth`, default 32: width of the snooped write data.
- `TrigAddr`, default 32'h0000_0008: byte address of the dump-control scratch register.
- `MinHoldCycles`, default 16: minimum number of cycles `trig_o` stays high per window. Legal values are ≥ 2.
- `CooldownCycles`, default 2: minimum number of cycles `trig_o` stays low between windows. Legal values are ≥ 2.
- `MaxWindowCycles`, default 0: auto-stop limit in cycles. 0 means unlimited. Used only with the timeout feature.
- `clk_i` in 1: system clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `en_i` in 1: block enable. When low, writes are ignored and any open window is closed.
- `reg_wr_valid_i` in 1: a register write is committed this cycle.
- `reg_wr_addr_i` in AddrWidth: write address.
- `reg_wr_data_i` in DataWidth: write data. Bit 0 = 1 requests start; bit 0 = 0 requests stop.
- `trig_o` out 1: registered dump-window level.
- `window_id_o` out 8: count of windows opened, modulo 256.
- `window_cycles_o` out 32: number of high cycles in the current or last window.
- `pending_o` out 1: a start request is queued during cooldown.
- `timeout_o` out 1: sticky flag, set when a window was closed by `MaxWindowCycles`.

## Operation
- A write is accepted when `en_i & reg_wr_valid_i & (reg_wr_addr_i == TrigAddr)` is true at a rising edge.
- States and transitions:
  - IDLE: a start write moves to ACTIVE. A stop write is ignored.
  - ACTIVE (`trig_o` = 1):
    - A stop write moves to COOLDOWN if `window_cycles_o` ≥ MinHoldCycles, otherwise to HOLD.
    - A start write is ignored.
  - HOLD (`trig_o` = 1): moves to COOLDOWN once `window_cycles_o` reaches MinHoldCycles. A start write while in HOLD cancels the stop and returns to ACTIVE.
  - COOLDOWN (`trig_o` = 0): lasts exactly CooldownCycles cycles, then goes to IDLE. If `pending_o` is set, it goes straight to ACTIVE instead.
- Start write during COOLDOWN: sets `pending_o`. A stop write during COOLDOWN clears `pending_o`.
- `en_i` low:
  - From ACTIVE or HOLD: go to COOLDOWN immediately; the MinHold guarantee is waived.
  - `pending_o` is cleared.
  - The block stays in IDLE while `en_i` is low.
- Counters:
  - `window_cycles_o` loads 0 on entry to ACTIVE from IDLE or COOLDOWN. It increments once per cycle while `trig_o` = 1 and saturates at 32'hFFFF_FFFF.
  - After a window closes, `window_cycles_o` holds its final value.
  - `window_id_o` increments on every 0→1 transition of `trig_o` and wraps 255→0.
- Write and state-change conflicts are resolved in favour of the write, except during HOLD, where the MinHold requirement always wins.

## Timing
- Values after reset: state IDLE; `trig_o` 0; `window_id_o` 0; `window_cycles_o` 0; `pending_o` 0; `timeout_o` 0. Reset mid-window drops `trig_o` at the next edge with no cooldown.
- Start accepted at edge N → `trig_o` = 1 from edge N+1.
- Stop accepted at edge M with M−N ≥ MinHoldCycles → `trig_o` = 0 from edge M+1. High time is M−N cycles.
- Stop earlier than that → high time is exactly MinHoldCycles cycles.
- Low gap between windows is ≥ CooldownCycles. A pending start rises on the first cycle after cooldown.
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- `VCD_TRIG_TIMEOUT_EN` defined:
  - With MaxWindowCycles ≠ 0, ACTIVE goes to COOLDOWN when `window_cycles_o` reaches max(MaxWindowCycles, MinHoldCycles), and `timeout_o` is set.
  - `timeout_o` is cleared only by reset.
- Macro undefined: the timeout logic is absent, MaxWindowCycles is ignored, and `timeout_o` is tied to 0.

## Test plan
- Reset, then start at edge 10 and stop at edge 50 → `trig_o` high for cycles 11..50, `window_cycles_o` = 40, `window_id_o` = 1.
- Start at edge 0, stop at edge 3, MinHoldCycles = 16 → `trig_o` high for exactly 16 cycles, then low for ≥ 2 cycles.
- Stop, then start written 1 cycle later during cooldown → `pending_o` = 1, `trig_o` low for exactly 2 cycles then high, `window_id_o` incremented.
- Write to TrigAddr+4, and a start write with `en_i` = 0 → no state change, `trig_o` stays 0.
- `VCD_TRIG_TIMEOUT_EN`, MaxWindowCycles = 100, start with no stop → `trig_o` high for 100 cycles, `timeout_o` = 1, `window_cycles_o` = 100.
- Assert `rst_ni` = 0 for 1 cycle mid-window → at the next edge all outputs are 0 and the block is in IDLE.

Source files
------------

// File: rtl/vcd_trig_gen.sv
// vcd_trig_gen: turns software start/stop writes to the dump-control scratch register
// into a clean trig_o window. Optional auto-stop enabled by macro VCD_TRIG_TIMEOUT_EN.
module vcd_trig_gen #(
  parameter int unsigned          AddrWidth       = 32,
  parameter int unsigned          DataWidth       = 32,
  parameter logic [AddrWidth-1:0] TrigAddr        = AddrWidth'(32'h0000_0008),
  parameter int unsigned          MinHoldCycles   = 16,
  parameter int unsigned          CooldownCycles  = 2,
  parameter int unsigned          MaxWindowCycles = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 reg_wr_valid_i,
  input  logic [AddrWidth-1:0] reg_wr_addr_i,
  input  logic [DataWidth-1:0] reg_wr_data_i,
  output logic                 trig_o,
  output logic [7:0]           window_id_o,
  output logic [31:0]          window_cycles_o,
  output logic                 pending_o,
  output logic                 timeout_o
);

  localparam int unsigned      CoolW    = (CooldownCycles > 2) ? $clog2(CooldownCycles) : 1;
  localparam logic [CoolW-1:0] CoolLast = CoolW'(CooldownCycles - 1);
  localparam logic [31:0]      MinHoldW = 32'(MinHoldCycles);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD, COOLDOWN} state_e;

  state_e           state_q, state_d;
  logic             trig_q, trig_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [7:0]       id_q, id_d;
  logic             pend_q, pend_d;
  logic [CoolW-1:0] cool_q, cool_d;
  logic             to_q, to_d;

  logic        acc, start_wr, stop_wr, held_min, cool_done, pend_eff, open_win, timeout_hit;
  logic [31:0] cnt_inc;

  logic unused_data;
  assign unused_data = ^reg_wr_data_i[DataWidth-1:1];

  // cnt_inc is the high-cycle count including the cycle ending at this edge
  always_comb begin
    acc       = en_i & reg_wr_valid_i & (reg_wr_addr_i == TrigAddr);
    start_wr  = acc &  reg_wr_data_i[0];
    stop_wr   = acc & ~reg_wr_data_i[0];
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
    held_min  = (cnt_inc >= MinHoldW);
    cool_done = (cool_q == CoolLast);
    pend_eff  = en_i & (start_wr | (pend_q & ~stop_wr));
  end

`ifdef VCD_TRIG_TIMEOUT_EN
  localparam int unsigned EffMax = (MaxWindowCycles > MinHoldCycles) ? MaxWindowCycles
                                                                      : MinHoldCycles;
  localparam logic [31:0] MaxW   = 32'(EffMax);
  assign timeout_hit = (MaxWindowCycles != 0) && (cnt_inc >= MaxW);
`else
  logic unused_max;
  assign unused_max  = ^(32'(MaxWindowCycles));
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = trig_q ? cnt_inc : cnt_q;
    id_d     = id_q;
    pend_d   = 1'b0;
    cool_d   = cool_q;
    to_d     = to_q;
    open_win = 1'b0;
    unique case (state_q)
      IDLE: open_win = start_wr;
      ACTIVE: begin
        if (!en_i || (stop_wr && held_min)) state_d = COOLDOWN;
        else if (stop_wr)                   state_d = HOLD;
        else if (timeout_hit) begin
          state_d = COOLDOWN;
          to_d    = 1'b1;
        end
      end
      // reaching MinHold beats a cancelling start on the same edge
      HOLD: begin
        if (!en_i || held_min) state_d = COOLDOWN;
        else if (start_wr)     state_d = ACTIVE;
      end
      COOLDOWN: begin
        if (!cool_done) begin
          cool_d = cool_q + CoolW'(1);
          pend_d = pend_eff;
        end else if (pend_eff) begin
          open_win = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (open_win) begin
      state_d = ACTIVE;
      cnt_d   = '0;
      id_d    = id_q + 8'd1;
    end
    if ((state_d == COOLDOWN) && (state_q != COOLDOWN)) cool_d = '0;
    trig_d = (state_d == ACTIVE) || (state_d == HOLD);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      trig_q  <= 1'b0;
      cnt_q   <= '0;
      id_q    <= '0;
      pend_q  <= 1'b0;
      cool_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= trig_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
      cool_q  <= cool_d;
      to_q    <= to_d;
    end
  end

  assign trig_o          = trig_q;
  assign window_id_o     = id_q;
  assign window_cycles_o = cnt_q;
  assign pending_o       = pend_q;
  assign timeout_o       = to_q;

endmodule

// File: tb/tb_vcd_trig_gen.sv
// Bench for vcd_trig_gen: directed test-plan sequences plus random writes, checked
// every cycle against a timestamp-based window model.
module tb_vcd_trig_gen;
  localparam int unsigned MINH  = 16;
  localparam int unsigned COOL  = 2;
  localparam int unsigned MAXW  = 100;
  localparam logic [31:0] TADDR = 32'h0000_0008;
`ifdef VCD_TRIG_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif
  localparam longint EFFMAX = (MAXW > MINH) ? MAXW : MINH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, wr_v;
  logic [31:0] wr_a, wr_d;
  logic        trig, pend, tout;
  logic [7:0]  wid;
  logic [31:0] wcyc;

  vcd_trig_gen #(
    .AddrWidth(32), .DataWidth(32), .TrigAddr(TADDR),
    .MinHoldCycles(MINH), .CooldownCycles(COOL), .MaxWindowCycles(MAXW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .reg_wr_valid_i(wr_v),
    .reg_wr_addr_i(wr_a), .reg_wr_data_i(wr_d), .trig_o(trig),
    .window_id_o(wid), .window_cycles_o(wcyc), .pending_o(pend), .timeout_o(tout)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Model: windows described by open edge, requested close edge and cooldown end edge
  longint e_now = 0, m_open = 0, m_close = -1, m_cend = 0, m_last = 0;
  bit     m_trig = 0, m_pend = 0, m_to = 0, m_cool = 0;
  int     m_id = 0;

  task automatic m_close_now();
    m_trig = 0; m_last = e_now - m_open; m_cend = e_now + COOL;
    m_cool = 1; m_pend = 0; m_close = -1;
  endtask

  task automatic m_open_now();
    m_trig = 1; m_open = e_now; m_id = (m_id + 1) % 256;
    m_cool = 0; m_pend = 0; m_close = -1;
  endtask

  task automatic model_edge();
    bit acc, st, sp;
    longint hi;
    e_now++;
    acc = en && wr_v && (wr_a == TADDR);
    st  = acc && wr_d[0];
    sp  = acc && !wr_d[0];
    if (!rst_n) begin
      m_trig = 0; m_id = 0; m_last = 0; m_pend = 0; m_to = 0; m_cool = 0; m_close = -1;
    end else if (m_trig) begin
      hi = e_now - m_open;
      if (!en) m_close_now();
      else if (m_close >= 0) begin
        if (e_now >= m_close) m_close_now();
        else if (st) m_close = -1;
      end else if (sp) begin
        m_close = (hi >= MINH) ? e_now : m_open + MINH;
        if (e_now >= m_close) m_close_now();
      end else if (TO_ON && (MAXW != 0) && (hi >= EFFMAX)) begin
        m_close_now();
        m_to = 1;
      end
    end else if (m_cool) begin
      if (e_now == m_cend) begin
        if (en && (st || (m_pend && !sp))) m_open_now();
        else begin m_cool = 0; m_pend = 0; end
      end else begin
        m_pend = en && (st || (m_pend && !sp));
      end
    end else if (st) begin
      m_open_now();
    end
  endtask

  int hi_len = 0, lo_len = 0, last_hi = 0, last_lo = 0;
  bit prev_t = 0;

  task automatic step(input bit r, input bit e, input bit v,
                      input logic [31:0] a, input logic [31:0] d);
    rst_n = r; en = e; wr_v = v; wr_a = a; wr_d = d;
    @(posedge clk);
    model_edge();
    #1;
    chk("trig",    32'(trig), 32'(m_trig));
    chk("win_id",  32'(wid),  32'(m_id));
    chk("win_cyc", wcyc,      32'(m_trig ? (e_now - m_open) : m_last));
    chk("pending", 32'(pend), 32'(m_pend));
    chk("timeout", 32'(tout), 32'(m_to));
    if (trig === 1'b1) begin
      if (!prev_t) begin last_lo = lo_len; lo_len = 0; end
      hi_len++;
    end else begin
      if (prev_t) begin last_hi = hi_len; hi_len = 0; end
      lo_len++;
    end
    prev_t = (trig === 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1, 1, 0, TADDR, 32'd0);
  endtask

  task automatic wr(input bit start);
    step(1, 1, 1, TADDR, {31'd0, start});
  endtask

  initial begin
    rst_n = 0; en = 0; wr_v = 0; wr_a = '0; wr_d = '0;
    repeat (3) step(0, 0, 0, TADDR, 32'd0);
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_id",   32'(wid),  32'd0);
    chk("rst_cyc",  wcyc,      32'd0);

    // long window: 40 high cycles
    idle(9); wr(1); idle(39); wr(0);
    chk("s1_high", 32'(last_hi), 32'd40);
    chk("s1_cyc",  wcyc,         32'd40);
    chk("s1_id",   32'(wid),     32'd1);
    idle(4);

    // early stop stretched to MinHold
    wr(1); idle(2); wr(0); idle(20);
    chk("s2_high", 32'(last_hi), MINH);
    chk("s2_id",   32'(wid),     32'd2);

    // start during cooldown queues a reopen
    wr(1); idle(20); wr(0); wr(1);
    chk("s3_pend", 32'(pend),    32'd1);
    idle(1);
    chk("s3_low",  32'(last_lo), COOL);
    chk("s3_trig", 32'(trig),    32'd1);
    chk("s3_id",   32'(wid),     32'd4);
    wr(0); idle(20);

    // wrong address and disabled block are ignored
    step(1, 1, 1, TADDR + 32'd4, 32'd1);
    chk("s4_addr", 32'(trig), 32'd0);
    step(1, 0, 1, TADDR, 32'd1);
    chk("s4_en",   32'(trig), 32'd0);
    idle(3);
    chk("s4_id",   32'(wid),  32'd4);

    // start with no stop
    wr(1); idle(110);
`ifdef VCD_TRIG_TIMEOUT_EN
    chk("s5_high", 32'(last_hi), 32'd100);
    chk("s5_to",   32'(tout),    32'd1);
    chk("s5_cyc",  wcyc,         32'd100);
`else
    chk("s5_trig", 32'(trig),    32'd1);
    chk("s5_to",   32'(tout),    32'd0);
    chk("s5_cyc",  wcyc,         32'd110);
`endif
    wr(0); idle(5);

    // reset mid-window, then an immediate restart with no cooldown
    wr(1); idle(5);
    step(0, 1, 0, TADDR, 32'd0);
    chk("s6_trig", 32'(trig), 32'd0);
    chk("s6_id",   32'(wid),  32'd0);
    chk("s6_cyc",  wcyc,      32'd0);
    chk("s6_pend", 32'(pend), 32'd0);
    chk("s6_to",   32'(tout), 32'd0);
    wr(1);
    chk("s6_restart", 32'(trig), 32'd1);
    chk("s6_id1",     32'(wid),  32'd1);
    wr(0); idle(20);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 499) != 0,
           $urandom_range(0, 15) != 0,
           $urandom_range(0, 4) == 0,
           ($urandom_range(0, 7) == 0) ? TADDR + 32'd4 : TADDR,
           32'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
